// File: rtl/i2c_master_byte_if.sv
// Command/status and pin bundle for the byte-level I2C initiator.
// The block itself uses the slave view; the host and bus environment use the master view.
interface i2c_master_byte_if;
  logic       m_START;
  logic [6:0] m_ADDR;
  logic       m_RW;
  logic [7:0] m_WDATA;
  logic [7:0] m_RDATA;
  logic       m_BUSY;
  logic       m_DONE;
  logic       m_NACK;
  logic       m_SCL_O;
  logic       m_SDA_OE;
  logic       m_SDA_I;

  modport master (
    output m_START, m_ADDR, m_RW, m_WDATA, m_SDA_I,
    input  m_RDATA, m_BUSY, m_DONE, m_NACK, m_SCL_O, m_SDA_OE
  );

  modport slave (
    input  m_START, m_ADDR, m_RW, m_WDATA, m_SDA_I,
    output m_RDATA, m_BUSY, m_DONE, m_NACK, m_SCL_O, m_SDA_OE
  );
endinterface

// File: rtl/i2c_master_byte.sv
// Byte-level I2C initiator: START, address+R/W, ACK check, one data byte, STOP.
// Each bit slot is four quarters of CLK_DIV clocks; SCL is low in q0-q1 and high in q2-q3.
module i2c_master_byte #(
  parameter int CLK_DIV = 4
) (
  input  logic             m_CLK,
  input  logic             m_RSTN,
  i2c_master_byte_if.slave bus
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [3:0] {
    IDLE, STRT, ADDR, AACK, WDAT, WACK, RDAT, RNAK, STOP, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    qtr_q, qtr_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    tx_q, tx_d;
  logic [7:0]    wdata_q, wdata_d;
  logic [6:0]    rx_q, rx_d;
  logic [7:0]    rdata_q, rdata_d;
  logic          rw_q, rw_d;
  logic          ack_q, ack_d;
  logic          nack_q, nack_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          scl_q, scl_d;
  logic          oe_q, oe_d;

  logic tick, sample, slot_end;

  assign tick     = (div_q == DIV_LAST);
  assign sample   = tick && (qtr_q == 2'd2);
  assign slot_end = tick && (qtr_q == 2'd3);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    qtr_d   = qtr_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    wdata_d = wdata_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    rw_d    = rw_q;
    ack_d   = ack_q;
    nack_d  = nack_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    if (state_q != IDLE && state_q != DONE) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) qtr_d = qtr_q + 2'd1;
    end
    if (sample) begin
      ack_d = bus.m_SDA_I;
      if (state_q == RDAT) rx_d = {rx_q[5:0], bus.m_SDA_I};
    end

    case (state_q)
      IDLE: begin
        if (bus.m_START) begin
          tx_d    = {bus.m_ADDR, bus.m_RW};
          rw_d    = bus.m_RW;
          wdata_d = bus.m_WDATA;
          nack_d  = 1'b0;
          busy_d  = 1'b1;
          div_d   = '0;
          qtr_d   = 2'd0;
          bit_d   = 3'd0;
          state_d = STRT;
        end
      end
      STRT: if (slot_end) state_d = ADDR;
      ADDR, WDAT: begin
        if (slot_end) begin
          tx_d  = {tx_q[6:0], 1'b0};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = (state_q == ADDR) ? AACK : WACK;
        end
      end
      AACK: begin
        if (slot_end) begin
          if (ack_q) begin
            nack_d  = 1'b1;
            state_d = STOP;
          end else if (rw_q) begin
            state_d = RDAT;
          end else begin
            tx_d    = wdata_q;
            state_d = WDAT;
          end
        end
      end
      WACK: begin
        if (slot_end) begin
          if (ack_q) nack_d = 1'b1;
          state_d = STOP;
        end
      end
      RDAT: begin
        // The last bit goes straight into the visible register so a read is complete at STOP.
        if (sample && bit_q == 3'd7) rdata_d = {rx_q, bus.m_SDA_I};
        if (slot_end) begin
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RNAK;
        end
      end
      RNAK: if (slot_end) state_d = STOP;
      STOP: begin
        if (slot_end) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Pin levels follow the next state so the registered pins line up with state_q.
    scl_d = 1'b1;
    oe_d  = 1'b0;
    case (state_d)
      STRT: oe_d = qtr_d[1];
      ADDR, WDAT: begin
        scl_d = qtr_d[1];
        oe_d  = ~tx_d[7];
      end
      AACK, WACK, RDAT, RNAK: scl_d = qtr_d[1];
      STOP: begin
        scl_d = qtr_d[1];
        oe_d  = (qtr_d != 2'd3);
      end
      default: ;
    endcase
  end

  always_ff @(posedge m_CLK or negedge m_RSTN) begin
    if (!m_RSTN) begin
      state_q <= IDLE;
      div_q   <= '0;
      qtr_q   <= 2'd0;
      bit_q   <= 3'd0;
      tx_q    <= 8'h00;
      wdata_q <= 8'h00;
      rx_q    <= 7'h00;
      rdata_q <= 8'h00;
      rw_q    <= 1'b0;
      ack_q   <= 1'b1;
      nack_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      scl_q   <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      qtr_q   <= qtr_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      wdata_q <= wdata_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      rw_q    <= rw_d;
      ack_q   <= ack_d;
      nack_q  <= nack_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      scl_q   <= scl_d;
      oe_q    <= oe_d;
    end
  end

  assign bus.m_RDATA  = rdata_q;
  assign bus.m_BUSY   = busy_q;
  assign bus.m_DONE   = done_q;
  assign bus.m_NACK   = nack_q;
  assign bus.m_SCL_O  = scl_q;
  assign bus.m_SDA_OE = oe_q;

endmodule

// File: tb/tb_i2c_master_byte.sv
// Randomized bench for i2c_master_byte: a behavioural I2C target/monitor on the pins,
// and a transaction-level model of latency, NACK and read-data results.
module tb_i2c_master_byte;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst0_n, rst1_n;
  logic       start_r [2];
  logic [6:0] addr_r  [2];
  logic       rw_r    [2];
  logic [7:0] wdata_r [2];
  logic       pull    [2];

  i2c_master_byte_if bus0 ();
  i2c_master_byte_if bus1 ();

  assign bus0.m_START = start_r[0];
  assign bus0.m_ADDR  = addr_r[0];
  assign bus0.m_RW    = rw_r[0];
  assign bus0.m_WDATA = wdata_r[0];
  assign bus0.m_SDA_I = ~(bus0.m_SDA_OE | pull[0]);
  assign bus1.m_START = start_r[1];
  assign bus1.m_ADDR  = addr_r[1];
  assign bus1.m_RW    = rw_r[1];
  assign bus1.m_WDATA = wdata_r[1];
  assign bus1.m_SDA_I = ~(bus1.m_SDA_OE | pull[1]);

  i2c_master_byte #(.CLK_DIV(4)) dut0 (.m_CLK(clk), .m_RSTN(rst0_n), .bus(bus0.slave));
  i2c_master_byte #(.CLK_DIV(1)) dut1 (.m_CLK(clk), .m_RSTN(rst1_n), .bus(bus1.slave));

  logic       scl_w [2], sda_w [2], oe_w [2], busy_w [2], done_w [2], nack_w [2], rstn_w [2];
  logic [7:0] rdata_w [2];
  assign scl_w[0]   = bus0.m_SCL_O;   assign scl_w[1]   = bus1.m_SCL_O;
  assign sda_w[0]   = bus0.m_SDA_I;   assign sda_w[1]   = bus1.m_SDA_I;
  assign oe_w[0]    = bus0.m_SDA_OE;  assign oe_w[1]    = bus1.m_SDA_OE;
  assign busy_w[0]  = bus0.m_BUSY;    assign busy_w[1]  = bus1.m_BUSY;
  assign done_w[0]  = bus0.m_DONE;    assign done_w[1]  = bus1.m_DONE;
  assign nack_w[0]  = bus0.m_NACK;    assign nack_w[1]  = bus1.m_NACK;
  assign rdata_w[0] = bus0.m_RDATA;   assign rdata_w[1] = bus1.m_RDATA;
  assign rstn_w[0]  = rst0_n;         assign rstn_w[1]  = rst1_n;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Target behaviour and bus decode, driven purely by what appears on SCL/SDA.
  logic       ack_addr_c [2], ack_data_c [2];
  logic [7:0] rbyte_c    [2];
  int         k      [2] = '{0, 0};
  int         starts [2] = '{0, 0};
  int         stops  [2] = '{0, 0};
  int         stop_k [2] = '{0, 0};
  logic [7:0] b0 [2], b1 [2];
  logic       bit9 [2], bit18 [2];
  logic       prev_scl [2] = '{1'b1, 1'b1};
  logic       prev_sda [2] = '{1'b1, 1'b1};

  function automatic logic slave_pull(input int d, input int kk);
    logic rd_ok;
    rd_ok = b0[d][0] && ack_addr_c[d];
    if (kk == 8) return ack_addr_c[d];
    if (kk == 9) return rd_ok && !rbyte_c[d][7];
    if (kk >= 10 && kk <= 16) return rd_ok && !rbyte_c[d][3'(16 - kk)];
    if (kk == 17) return !b0[d][0] && ack_addr_c[d] && ack_data_c[d];
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    logic s, a;
    int   kk;
    for (int d = 0; d < 2; d++) begin
      s  = scl_w[d];
      a  = sda_w[d];
      kk = k[d];
      if (!rstn_w[d]) begin
        pull[d] <= 1'b0;
      end else if (prev_scl[d] && s && (prev_sda[d] != a)) begin
        if (!a) begin
          starts[d] <= starts[d] + 1;
          k[d]      <= 0;
        end else begin
          stops[d]  <= stops[d] + 1;
          stop_k[d] <= kk;
        end
      end else if (!prev_scl[d] && s) begin
        kk   = kk + 1;
        k[d] <= kk;
        if (kk <= 8)       b0[d]    <= {b0[d][6:0], a};
        else if (kk == 9)  bit9[d]  <= a;
        else if (kk <= 17) b1[d]    <= {b1[d][6:0], a};
        else if (kk == 18) bit18[d] <= a;
      end else if (prev_scl[d] && !s) begin
        pull[d] <= slave_pull(d, kk);
      end
      prev_scl[d] <= s;
      prev_sda[d] <= a;
    end
  end

  // Transaction-level expectations.
  logic [7:0] model_rdata [2];
  logic       model_nack  [2];
  int         e_d, acc_cyc, s_snap, p_snap;
  logic [6:0] e_addr;
  logic       e_rw, e_aa, e_ad;
  logic [7:0] e_wd, e_rb;

  function automatic int div_of(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  task automatic set_in(input int d, input logic s, input logic [6:0] a, input logic r,
                        input logic [7:0] w);
    start_r[d] = s; addr_r[d] = a; rw_r[d] = r; wdata_r[d] = w;
  endtask

  task automatic start_txn(input int d, input logic [6:0] a, input logic r, input logic [7:0] w,
                           input logic aa, input logic ad, input logic [7:0] rb, input int exp_wait);
    int  waits;
    bit  acc;
    check_val("idle_busy", busy_w[d], 1'b0);
    check_val("nack_hold", nack_w[d], model_nack[d]);
    e_d = d; e_addr = a; e_rw = r; e_wd = w; e_aa = aa; e_ad = ad; e_rb = rb;
    ack_addr_c[d] = aa; ack_data_c[d] = ad; rbyte_c[d] = rb;
    s_snap = starts[d]; p_snap = stops[d];
    if (r && aa) model_rdata[d] = rb;
    model_nack[d] = !aa || (!r && !ad);
    set_in(d, 1'b1, a, r, w);
    waits = 0;
    acc   = 1'b0;
    while (!acc && waits < 8) begin
      @(negedge clk);
      waits++;
      if (busy_w[d]) acc = 1'b1;
    end
    set_in(d, 1'b0, a, r, w);
    acc_cyc = cyc;
    check_val("accept_wait", waits, exp_wait);
  endtask

  task automatic finish_txn(input bit reissue);
    bit seen;
    int lat, exp_lat, exp_rises;
    if (reissue) begin
      repeat (5) @(negedge clk);
      set_in(e_d, 1'b1, ~e_addr, ~e_rw, ~e_wd);
      @(negedge clk);
      set_in(e_d, 1'b0, ~e_addr, ~e_rw, ~e_wd);
    end
    seen = 1'b0;
    for (int i = 0; i < 3000 && !seen; i++) begin
      @(negedge clk);
      if (done_w[e_d]) seen = 1'b1;
    end
    check_val("done_seen", seen, 1'b1);
    lat       = cyc - acc_cyc;
    exp_lat   = (e_aa ? 20 : 11) * 4 * div_of(e_d);
    exp_rises = e_aa ? 19 : 10;
    $display("txn dut=%0d addr=%02h rw=%0d wdata=%02h aack=%0d dack=%0d rbyte=%02h lat=%0d nack=%0d rdata=%02h",
             e_d, e_addr, e_rw, e_wd, e_aa, e_ad, e_rb, lat, nack_w[e_d], rdata_w[e_d]);
    check_val("latency", lat, exp_lat);
    check_val("done_busy", busy_w[e_d], 1'b0);
    check_val("nack", nack_w[e_d], model_nack[e_d]);
    check_val("rdata", rdata_w[e_d], model_rdata[e_d]);
    check_val("starts", starts[e_d] - s_snap, 1);
    check_val("stops", stops[e_d] - p_snap, 1);
    check_val("scl_rises", stop_k[e_d], exp_rises);
    check_val("addr_byte", b0[e_d], {e_addr, e_rw});
    check_val("addr_ack_line", bit9[e_d], !e_aa);
    if (e_aa) begin
      check_val("data_byte", b1[e_d], e_rw ? e_rb : e_wd);
      check_val("data_ack_line", bit18[e_d], e_rw ? 1'b1 : !e_ad);
    end
  endtask

  task automatic txn(input int d, input logic [6:0] a, input logic r, input logic [7:0] w,
                     input logic aa, input logic ad, input logic [7:0] rb, input bit reissue);
    start_txn(d, a, r, w, aa, ad, rb, 1);
    finish_txn(reissue);
    @(negedge clk);
    check_val("done_pulse", done_w[d], 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      set_in(d, 1'b0, 7'h00, 1'b0, 8'h00);
      ack_addr_c[d] = 1'b0; ack_data_c[d] = 1'b0; rbyte_c[d] = 8'h00;
      model_rdata[d] = 8'h00;
      model_nack[d]  = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_val("rst_scl", scl_w[d], 1'b1);
      check_val("rst_oe", oe_w[d], 1'b0);
      check_val("rst_busy", busy_w[d], 1'b0);
      check_val("rst_done", done_w[d], 1'b0);
      check_val("rst_nack", nack_w[d], 1'b0);
      check_val("rst_rdata", rdata_w[d], 8'h00);
    end
    rst0_n = 1'b1;
    rst1_n = 1'b1;
    repeat (2) @(negedge clk);

    txn(0, 7'h55, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0);
    txn(0, 7'h55, 1'b1, 8'h00, 1'b1, 1'b1, 8'hC3, 1'b0);
    txn(0, 7'h55, 1'b0, 8'h5A, 1'b0, 1'b1, 8'h00, 1'b0);
    txn(0, 7'h12, 1'b1, 8'h00, 1'b0, 1'b1, 8'h99, 1'b0);
    txn(0, 7'h33, 1'b0, 8'h96, 1'b1, 1'b0, 8'h00, 1'b1);

    // A request raised in the DONE clock is only taken one clock later, in IDLE.
    start_txn(0, 7'h41, 1'b0, 8'h0F, 1'b1, 1'b1, 8'h00, 1);
    finish_txn(1'b0);
    start_txn(0, 7'h42, 1'b1, 8'h00, 1'b1, 1'b1, 8'h7E, 2);
    finish_txn(1'b0);
    @(negedge clk);
    check_val("done_pulse", done_w[0], 1'b0);

    // Abort during address bit 3 (SCL low, SDA pulled for a 0 bit).
    start_txn(0, 7'h26, 1'b0, 8'h3C, 1'b1, 1'b1, 8'h00, 1);
    repeat (64) @(negedge clk);
    check_val("abort_bitpos", k[0], 3);
    check_val("abort_pre_busy", busy_w[0], 1'b1);
    rst0_n = 1'b0;
    #1;
    check_val("abort_scl", scl_w[0], 1'b1);
    check_val("abort_oe", oe_w[0], 1'b0);
    check_val("abort_busy", busy_w[0], 1'b0);
    check_val("abort_rdata", rdata_w[0], 8'h00);
    model_rdata[0] = 8'h00;
    model_nack[0]  = 1'b0;
    repeat (3) @(negedge clk);
    rst0_n = 1'b1;
    repeat (2) @(negedge clk);
    txn(0, 7'h26, 1'b0, 8'h3C, 1'b1, 1'b1, 8'h00, 1'b0);

    for (int i = 0; i < 10; i++) begin
      txn(0, 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) != 0),
          8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
    end

    txn(1, 7'h55, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0);
    txn(1, 7'h2B, 1'b1, 8'h00, 1'b1, 1'b1, 8'h3C, 1'b0);
    txn(1, 7'h70, 1'b1, 8'h00, 1'b0, 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 5; i++) begin
      txn(1, 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 4) != 0), 1'($urandom_range(0, 3) != 0),
          8'($urandom_range(0, 255)), bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_master_byte.md
Name: i2c_master_byte

Overview:
- Byte-level I2C initiator that drives SCL and open-drain SDA.
- Performs one complete transaction per request: START, 7-bit address + R/W, address ACK check, one data byte written or read, STOP.
- Bus-side counterpart to the team's I2C slave; sits between a host register/command interface and the I2C pins.
- SCL is derived from the system clock by a quarter-period divider.

Parameters:
- CLK_DIV, 4, system clocks per SCL quarter period (legal range ≥1); one SCL bit = 4×CLK_DIV clocks.

Ports:
- m_CLK  in  1  system clock, all logic on rising edge
- m_RSTN  in  1  asynchronous active-low reset
- m_START  in  1  request pulse; accepted only when m_BUSY=0
- m_ADDR  in  7  target address, latched on accept
- m_RW  in  1  latched on accept; 0=write, 1=read (standard I2C bit0)
- m_WDATA  in  8  write byte, latched on accept
- m_RDATA  out  8  byte received on a read
- m_BUSY  out  1  high from the accept edge until DONE
- m_DONE  out  1  one-clock completion pulse
- m_NACK  out  1  set if address or write data was not acknowledged
- m_SCL_O  out  1  SCL level (1=released/high)
- m_SDA_OE  out  1  1=pull SDA low, 0=release
- m_SDA_I  in  1  sampled SDA line

Behaviour:
- Reset (asynchronous, while m_RSTN=0):
  - m_SCL_O=1, m_SDA_OE=0, m_BUSY=0, m_DONE=0, m_NACK=0, m_RDATA=0.
  - FSM to IDLE, counters cleared.
  - Reset mid-transaction aborts immediately. No STOP is generated; the bus is left released.
- Timing base:
  - Quarter counter q=0..3; each quarter lasts CLK_DIV clocks.
  - Bit slots: q0,q1 SCL low; q2,q3 SCL high.
  - SDA changes only at entry to q0.
  - m_SDA_I is sampled on the last clock of q2.
- States:
  - IDLE: SCL=1, SDA released. m_START=1 latches ADDR/RW/WDATA, clears m_NACK, sets m_BUSY, and moves to STRT.
  - STRT (1 slot): q0–q1 SDA released, q2–q3 SDA low, SCL high throughout.
  - ADDR (8 slots): shifts {ADDR,RW} MSB-first; OE = ~bit.
  - AACK (1 slot): SDA released; sample. If sampled 1, set m_NACK and go to STOP; else if RW=0 go to WDAT, else go to RDAT.
  - WDAT (8 slots): shifts WDATA MSB-first.
  - WACK (1 slot): release SDA and sample; a sampled 1 sets m_NACK. Then STOP.
  - RDAT (8 slots): SDA released; shift in sampled bits MSB-first; m_RDATA updates after bit 0.
  - RNAK (1 slot): master NACK, SDA released. Then STOP.
  - STOP (1 slot): q0–q2 SDA low, q3 SDA released, SCL high in q2–q3.
  - DONE: one clock with m_DONE=1 and m_BUSY=0, then IDLE.
- Latency from the accept edge to m_DONE:
  - Full transaction: 20×4×CLK_DIV clocks.
  - Address NACK: 11×4×CLK_DIV clocks.
- m_START while busy is ignored. Input changes after accept have no effect.
- m_START in the DONE clock is ignored; it is accepted the next clock in IDLE.
- m_RDATA holds its value until the next completed read. It is unchanged by writes and by address NACK.
- m_NACK holds until the next accept.
- Bit counter wraps 7→0 at each byte boundary. There are no extra SCL pulses between bytes and ACK slots.

Test Plan:
- Write, CLK_DIV=4, addr 0x55, data 0xA5, bench ACKs -> SDA bytes 0xAA then 0xA5 valid while SCL high; STOP seen; m_DONE pulse 320 clocks after accept; m_NACK=0.
- Read addr 0x55, bench drives 0xC3 and ACKs address -> first byte 0xAB; m_RDATA=0xC3 at DONE; SDA released in RNAK slot; STOP generated.
- Address NACK (bench never pulls low) -> no data slots; STOP; m_NACK=1 at DONE 176 clocks after accept; m_RDATA unchanged.
- Write data NACK -> full 20 slots; m_NACK=1; re-pulse m_START 5 clocks into a transaction and change m_WDATA -> no effect on the byte sent.
- Assert m_RSTN=0 during ADDR bit 3 -> same clock: m_SCL_O=1, m_SDA_OE=0, m_BUSY=0. After release, a new write of 0x3C completes correctly.
- CLK_DIV=1 write -> DONE 80 clocks after accept; START/STOP ordering (SDA edges only while SCL high) checked by a protocol assertion for all scenarios.
